// File: rtl/pad_share_pkg.sv
// Shared types and helpers for the pad-share arbiter.
//   state_e  : arbiter phase (IDLE / TURN / GRANT)
//   own_w    : width of an index into N requesters (at least 1 bit)
//   slice_lo : low bit of requester idx's field in a packed per-requester bus
package pad_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        GRANT = 2'd2
    } state_e;

    function automatic int own_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/pad_share_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
//   req    : request vector
//   ptr    : highest-priority index this round
//   winner : selected index (0 when nothing is requested)
//   valid  : any request present
module rr_pick
    import pad_share_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [own_w(N_REQ)-1:0] ptr,
    output logic [own_w(N_REQ)-1:0] winner,
    output logic                    valid
);

    localparam int OWN_W = own_w(N_REQ);

    logic found;
    int   idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                winner = OWN_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/pad_share_arbiter.sv
// Time-shares one pad group between N_REQ peripherals.
// Round-robin grant with an all-OE-off turnaround before every grant, and an
// advisory yield to an owner that holds the pads too long while others wait.
//   req/gnt/yield         : per-requester handshake (gnt one-hot, registered)
//   periph_o/oe/periph_i  : packed per-requester pad buses, PAD_W bits each
//   pad_o/pad_oe/pad_i    : pad ring side
//   busy, owner           : status (owner = selected/granted index)
module pad_share_arbiter
    import pad_share_pkg::*;
#(
    parameter int               N_REQ      = 3,
    parameter int               PAD_W      = 4,
    parameter int               TURNAROUND = 2,
    parameter int               MAX_HOLD   = 1024,
    parameter logic [PAD_W-1:0] IDLE_IN    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          yield,
    input  logic [N_REQ*PAD_W-1:0]    periph_o,
    input  logic [N_REQ*PAD_W-1:0]    periph_oe,
    output logic [N_REQ*PAD_W-1:0]    periph_i,
    output logic [PAD_W-1:0]          pad_o,
    output logic [PAD_W-1:0]          pad_oe,
    input  logic [PAD_W-1:0]          pad_i,
    output logic                      busy,
    output logic [own_w(N_REQ)-1:0]   owner
);

    localparam int OWN_W = own_w(N_REQ);
    localparam int TC_W  = $clog2(TURNAROUND + 1);
    localparam int HC_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    state_e             state_q, state_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [OWN_W-1:0]   ptr_q, ptr_d;
    logic [TC_W-1:0]    tcnt_q, tcnt_d;
    logic [HC_W-1:0]    hcnt_q, hcnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   yield_q, yield_d;

    logic [OWN_W-1:0]   win;
    logic               win_vld;
    logic               contended;
    int                 own_lo;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (win),
        .valid  (win_vld)
    );

    // In GRANT gnt_q is the owner's one-hot, so this is "anyone else waiting".
    assign contended = |(req & ~gnt_q);
    assign own_lo    = slice_lo(int'(owner_q), PAD_W);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        tcnt_d  = tcnt_q;
        hcnt_d  = hcnt_q;
        gnt_d   = gnt_q;
        yield_d = yield_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d = win;
                    tcnt_d  = TC_W'(TURNAROUND - 1);
                    state_d = TURN;
                end
            end
            TURN: begin
                if (!req[owner_q]) begin
                    // Abandoned before grant: pointer untouched.
                    state_d = IDLE;
                end else if (tcnt_q == '0) begin
                    state_d        = GRANT;
                    gnt_d          = '0;
                    gnt_d[owner_q] = 1'b1;
                    hcnt_d         = '0;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    yield_d = '0;
                    ptr_d   = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                end else begin
                    // Yield follows one edge after the counter saturates.
                    if (MAX_HOLD != 0 && hcnt_q == HC_W'(MAX_HOLD))
                        yield_d[owner_q] = 1'b1;
                    if (contended && hcnt_q != HC_W'(MAX_HOLD))
                        hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            tcnt_q  <= '0;
            hcnt_q  <= '0;
            gnt_q   <= '0;
            yield_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            tcnt_q  <= tcnt_d;
            hcnt_q  <= hcnt_d;
            gnt_q   <= gnt_d;
            yield_q <= yield_d;
        end
    end

    // Pad mux is combinational off registered state; async reset forces IDLE,
    // so pads go quiet the instant rst rises. OE is gated by the live req so
    // it drops in the same cycle the owner lets go.
    always_comb begin
        pad_o    = '0;
        pad_oe   = '0;
        periph_i = {N_REQ{IDLE_IN}};
        if (state_q == GRANT) begin
            pad_o  = periph_o[own_lo +: PAD_W];
            pad_oe = periph_oe[own_lo +: PAD_W] & {PAD_W{req[owner_q]}};
            periph_i[own_lo +: PAD_W] = pad_i;
        end
    end

    assign gnt   = gnt_q;
    assign yield = yield_q;
    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_pad_share_arbiter.sv
module tb_pad_share_arbiter;

    localparam int N  = 3;
    localparam int W  = 4;
    localparam int TA = 2;
    localparam int MH = 16;
    localparam logic [W-1:0] IDLE = 4'b0010;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, gnt, yield;
    logic [N*W-1:0]  periph_o, periph_oe, periph_i;
    logic [W-1:0]    pad_o, pad_oe, pad_i;
    logic            busy;
    logic [1:0]      owner;

    int n_chk = 0;
    int n_err = 0;

    pad_share_arbiter #(
        .N_REQ(N), .PAD_W(W), .TURNAROUND(TA), .MAX_HOLD(MH), .IDLE_IN(IDLE)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .yield(yield),
        .periph_o(periph_o), .periph_oe(periph_oe), .periph_i(periph_i),
        .pad_o(pad_o), .pad_oe(pad_oe), .pad_i(pad_i),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Reference: who holds the pads, how many edges until the grant lands,
    // how long the holder has been contended, and the rotating start point.
    bit holding;     // pads granted
    bit waiting;     // winner chosen, turnaround in progress
    int m_own, m_ptr, m_wait, m_hold;
    bit m_yld;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        holding = 0; waiting = 0; m_own = 0; m_ptr = 0;
        m_wait = 0; m_hold = 0; m_yld = 0;
    endtask

    task automatic m_edge();
        if (holding) begin
            if (!req[m_own]) begin
                holding = 0; m_yld = 0; m_ptr = (m_own + 1) % N;
            end else begin
                if (m_hold == MH) m_yld = 1;
                if ((req & ~(N'(1) << m_own)) != 0 && m_hold < MH) m_hold++;
            end
        end else if (waiting) begin
            if (!req[m_own]) waiting = 0;
            else if (m_wait == 1) begin waiting = 0; holding = 1; m_hold = 0; end
            else m_wait--;
        end else begin
            for (int i = 0; i < N; i++) begin
                int k = (m_ptr + i) % N;
                if (req[k]) begin m_own = k; m_wait = TA; waiting = 1; break; end
            end
        end
    endtask

    task automatic check_all();
        logic [N*W-1:0] e_pi;
        for (int k = 0; k < N; k++)
            e_pi[k*W +: W] = (holding && k == m_own) ? pad_i : IDLE;
        chk("gnt",   gnt,   holding ? (32'd1 << m_own) : 32'd0);
        chk("yield", yield, (holding && m_yld) ? (32'd1 << m_own) : 32'd0);
        chk("busy",  busy,  holding || waiting);
        chk("owner", owner, m_own);
        chk("pad_o", pad_o, holding ? periph_o[m_own*W +: W] : 4'h0);
        chk("pad_oe", pad_oe, (holding && req[m_own]) ? periph_oe[m_own*W +: W] : 4'h0);
        chk("periph_i", periph_i, e_pi);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) m_reset(); else m_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (gnt == '0 && n < 12) begin step(); n++; end
        chk("gnt_wait_ok", gnt != '0, 1);
    endtask

    int ord[4] = '{0, 1, 2, 0};
    int r;

    initial begin
        rst = 1; req = '0; periph_o = '0; periph_oe = '0; pad_i = '0;
        m_reset();
        step(); step();
        chk("rst_periph_i", periph_i, 12'h222);
        chk("rst_busy", busy, 0);
        rst = 0;

        // single request, latency and pad routing
        periph_o = 12'h00A; periph_oe = 12'h00F; pad_i = 4'h5; req = 3'b001;
        step(); chk("t2_busy", busy, 1); chk("t2_gnt_e0", gnt, 0);
        step(); chk("t2_gnt_e1", gnt, 0);
        step(); chk("t2_gnt_e2", gnt, 3'b001);
        chk("t2_pad_o", pad_o, 4'hA); chk("t2_pad_oe", pad_oe, 4'hF);
        chk("t2_periph_i", periph_i, 12'h225);
        step(); step();

        // release: OE off in the same cycle req drops
        req = 3'b000; #1;
        chk("t6_oe_same_cycle", pad_oe, 0); chk("t6_gnt_held", gnt, 3'b001);
        step(); chk("t6_gnt_clear", gnt, 0);

        // round robin from a fresh pointer
        rst = 1; m_reset(); step(); rst = 0;
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            wait_gnt();
            chk("rr_order", owner, ord[g]);
            repeat (4) step();
            r = owner; req[r] = 1'b0; step(); req[r] = 1'b1;
        end

        // yield under contention
        req = 3'b010; wait_gnt(); chk("t4_gnt1", gnt, 3'b010);
        req = 3'b110;
        repeat (16) step(); chk("t4_no_yield_yet", yield, 0);
        step(); chk("t4_yield", yield, 3'b010);
        req = 3'b100;
        step(); chk("t4_yield_clr", yield, 0); chk("t4_gnt_clr", gnt, 0);
        step(); step(); step(); chk("t4_gnt2", gnt, 3'b100);

        // abort in turnaround leaves pointer alone
        req = 3'b000; step(); step();
        req = 3'b001; step(); chk("t5_busy", busy, 1);
        req = 3'b000; step(); chk("t5_idle", busy, 0); chk("t5_no_gnt", gnt, 0);
        req = 3'b111; step(); chk("t5_ptr", owner, 0);
        req = 3'b000; repeat (3) step();

        // randomized traffic
        repeat (1500) begin
            periph_o = N*W'($urandom); periph_oe = N*W'($urandom); pad_i = W'($urandom);
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 9) == 0) req[k] = ~req[k];
            if ($urandom_range(0, 299) == 0) begin rst = 1; m_reset(); end
            else rst = 0;
            step();
        end
        rst = 0;

        // async reset in the middle of a grant
        req = 3'b000; step(); step();
        periph_oe = 12'hFFF; req = 3'b001;
        wait_gnt(); chk("t1_gnt", gnt, 3'b001); chk("t1_oe", pad_oe, 4'hF);
        #2 rst = 1; m_reset(); #1;
        chk("t1_pad_oe", pad_oe, 0); chk("t1_gnt_rst", gnt, 0);
        chk("t1_yield", yield, 0); chk("t1_periph_i", periph_i, 12'h222);
        step(); rst = 0; step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pad_share_arbiter.md
Name: pad_share_arbiter

Overview:
Time-shares one external pad group (e.g. SPI SCK/MOSI/MISO/CS on pads 50-53, or UART RX/TX on 58-59) between N_REQ peripheral requesters inside asic_top.
- Round-robin arbitration; exactly one peripheral owns the pads at a time.
- Guaranteed all-OE-off turnaround gap between owners, so there is no pad contention.
- Asks the current owner to yield when it has held the pads too long while others wait.
- Sits between the peripheral mux and the pad ring.

Parameters:
N_REQ, 3, number of requesting peripherals (2..8)
PAD_W, 4, pads in the shared group
TURNAROUND, 2, cycles with all pad_oe forced low before any grant (must be >= 1)
MAX_HOLD, 1024, contended-hold cycles before yield is raised; 0 disables yield
IDLE_IN, 4'b0000, value driven on periph_i of non-owners, per pad (PAD_W bits); set 1 on UART RX pads

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req  in  N_REQ  per-peripheral request; level, held for the whole transfer
gnt  out  N_REQ  one-hot grant, registered
yield  out  N_REQ  owner should finish and drop req; registered
periph_o  in  N_REQ*PAD_W  per-peripheral pad output values, requester k at [k*PAD_W +: PAD_W]
periph_oe  in  N_REQ*PAD_W  per-peripheral pad output enables
periph_i  out  N_REQ*PAD_W  pad input fan-back to each peripheral
pad_o  out  PAD_W  to pad ring
pad_oe  out  PAD_W  to pad ring
pad_i  in  PAD_W  from pad ring
busy  out  1  state != IDLE
owner  out  $clog2(N_REQ)  index of selected/granted requester

Behaviour:
Clock and reset
- One clock: clk.
- Reset is asynchronous and active-high: rst.
- While rst is high: gnt=0, yield=0, pad_o=0, pad_oe=0 (combinational, effective immediately), periph_i = IDLE_IN replicated to all requesters, busy=0, owner=0, rr pointer=0, state=IDLE, counters=0.
- Reset mid-transfer drops the grant with no handshake.

States: IDLE, TURN, GRANT.
- IDLE: if any req is high, the rr_pick winner is the first requester at or after the pointer, wrapping modulo N_REQ. Register owner=winner, tcnt=TURNAROUND-1, go to TURN. With no req, stay in IDLE.
- TURN:
  - pad_oe=0 and gnt=0.
  - If req[owner] drops, return to IDLE; the pointer is unchanged.
  - Otherwise decrement tcnt. When tcnt==0, go to GRANT and set gnt[owner]=1.
  - Latency: req rising before edge 0 gives busy after edge 0 and gnt high after edge TURNAROUND.
- GRANT:
  - pad_o = periph_o[owner].
  - pad_oe = periph_oe[owner] & {PAD_W{req[owner]}}. The gating means OE is off in the same cycle req drops.
  - periph_i[owner] = pad_i; every other requester gets IDLE_IN. Both paths are combinational, zero latency.
  - Requests from other requesters are ignored until release.
  - Release: req[owner]==0 at an edge clears gnt, clears yield, sets pointer=(owner+1) mod N_REQ, and goes to IDLE. Re-arbitration happens the next cycle, so the minimum owner-to-owner gap is 1+TURNAROUND cycles of pad_oe=0.
- Outside GRANT: pad_o=0, pad_oe=0, and all periph_i=IDLE_IN.

Hold counter (GRANT only)
- Increments on each cycle where any other req is high; saturates at MAX_HOLD.
- Holds its value while uncontended. Cleared on entering GRANT.
- When it reaches MAX_HOLD (and MAX_HOLD != 0), yield[owner] goes to 1 on the following edge and stays high until release.
- yield is advisory; the arbiter never preempts.

Other rules
- A requester dropping and re-raising req in consecutive cycles re-arbitrates normally; it loses priority to the others.
- At most one gnt bit is high at any time; gnt is never high outside GRANT.

Decomposition:
- Package pad_share_pkg: state enum (IDLE/TURN/GRANT), OWN_W = $clog2(N_REQ) helper function, and the slice-index helper function for packed per-requester buses.
- Sub-module rr_pick: combinational round-robin winner. Inputs: req vector and pointer. Outputs: winner index and valid.

Test Plan (N_REQ=3, PAD_W=4, TURNAROUND=2, MAX_HOLD=16, IDLE_IN=4'b0010):
1. Reset: assert rst mid-GRANT with periph_oe[0]=4'hF -> pad_oe=0 immediately; gnt=0, yield=0, periph_i=12'h222.
2. Single request: req=3'b001 -> gnt=3'b001 exactly 2 edges after busy rises; with periph_o[0]=4'hA, oe=4'hF -> pad_o=4'hA, pad_oe=4'hF; pad_i=4'h5 -> periph_i[0]=5, periph_i[1]=periph_i[2]=2.
3. Round-robin: req=3'b111 held, each owner releases after 4 cycles -> grant order 0,1,2,0; pad_oe=0 for >=3 cycles between grants; never two gnt bits high.
4. Yield: owner 1 holds while req[2] is high -> yield=3'b010 after 16 contended cycles; drop req[1] -> yield=0, then gnt=3'b100 after the turnaround.
5. Abort in TURN: req[0] pulses high for 1 cycle -> busy for <=2 cycles, no gnt, pad_oe stays 0; pointer still 0.
6. Release OE gating: owner drops req while periph_oe=4'hF -> pad_oe=0 in that same cycle; gnt clears next edge.
